// File: rtl/pacman_sprite_gen_if.sv
// Pixel-stage bus between the VGA timing core, the sprite renderer and its consumers.
interface pacman_sprite_gen_if;
  logic [9:0] h;
  logic [9:0] v;
  logic       hs_in;
  logic       vs_in;
  logic [1:0] dir_req;
  logic       dir_valid;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic       hs_out;
  logic       vs_out;
  logic [9:0] px_x;
  logic [9:0] px_y;
  logic       frame_tick;

  modport master (
    output h, v, hs_in, vs_in, dir_req, dir_valid,
    input  r, g, b, hs_out, vs_out, px_x, px_y, frame_tick
  );

  modport slave (
    input  h, v, hs_in, vs_in, dir_req, dir_valid,
    output r, g, b, hs_out, vs_out, px_x, px_y, frame_tick
  );
endinterface

// File: rtl/pacman_sprite_gen.sv
// Pac-Man sprite renderer: per-frame movement FSM, mouth animation and a
// two-stage pixel pipeline producing RGB444 with matching sync delay.
module pacman_sprite_gen #(
  parameter int SIZE     = 16,
  parameter int START_X  = 312,
  parameter int START_Y  = 232,
  parameter int STEP     = 1,
  parameter int ANIM_DIV = 8
) (
  input logic               pclk,
  input logic               rst_n,
  pacman_sprite_gen_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MOVING  = 2'd1;
  localparam logic [1:0] BLOCKED = 2'd2;

  localparam logic [1:0] DIR_R = 2'd0;
  localparam logic [1:0] DIR_L = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;
  localparam logic [1:0] DIR_D = 2'd3;

  localparam logic [1:0] CLOSED = 2'd0;
  localparam logic [1:0] OPEN   = 2'd1;
  localparam logic [1:0] WIDE   = 2'd2;

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic signed [11:0] X_MAX  = 12'(640 - SIZE);
  localparam logic signed [11:0] Y_MAX  = 12'(480 - SIZE);
  localparam logic signed [11:0] STEP_S = 12'(STEP);

  logic          vs_d, frame_tick_q;
  logic [1:0]    state, dir, pend, pstep;
  logic          seen_valid;
  logic [CW-1:0] anim_cnt;
  logic [9:0]    px_x_q, px_y_q;

  logic [1:0]        pend_eff;
  logic              any_valid;
  logic signed [11:0] nx, ny;
  logic [9:0]        cl_x, cl_y;
  logic              at_bound;

  // Effective request for this cycle (same-cycle strobe bypasses the latch) and the clamped step
  always_comb begin
    pend_eff  = bus.dir_valid ? bus.dir_req : pend;
    any_valid = seen_valid | bus.dir_valid;
    nx = $signed({2'b00, px_x_q});
    ny = $signed({2'b00, px_y_q});
    case (pend_eff)
      DIR_R:   nx = nx + STEP_S;
      DIR_L:   nx = nx - STEP_S;
      DIR_U:   ny = ny - STEP_S;
      default: ny = ny + STEP_S;
    endcase
    cl_x = nx[11] ? '0 : ((nx > X_MAX) ? X_MAX[9:0] : nx[9:0]);
    cl_y = ny[11] ? '0 : ((ny > Y_MAX) ? Y_MAX[9:0] : ny[9:0]);
    case (pend_eff)
      DIR_R:   at_bound = (cl_x == X_MAX[9:0]);
      DIR_L:   at_bound = (cl_x == '0);
      DIR_U:   at_bound = (cl_y == '0);
      default: at_bound = (cl_y == Y_MAX[9:0]);
    endcase
  end

  // Frame tick from vsync falling edge; movement FSM and animation advance only on that tick
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d         <= 1'b1;
      frame_tick_q <= 1'b0;
      state        <= IDLE;
      dir          <= DIR_R;
      pend         <= DIR_R;
      seen_valid   <= 1'b0;
      anim_cnt     <= '0;
      pstep        <= '0;
      px_x_q       <= 10'(START_X);
      px_y_q       <= 10'(START_Y);
    end else begin
      vs_d         <= bus.vs_in;
      frame_tick_q <= vs_d & ~bus.vs_in;
      if (bus.dir_valid) begin
        pend       <= bus.dir_req;
        seen_valid <= 1'b1;
      end
      if (frame_tick_q) begin
        case (state)
          IDLE: if (any_valid) state <= MOVING;
          MOVING: begin
            dir    <= pend_eff;
            px_x_q <= cl_x;
            px_y_q <= cl_y;
            if (at_bound) state <= BLOCKED;
            if (anim_cnt == CW'(ANIM_DIV - 1)) begin
              anim_cnt <= '0;
              pstep    <= pstep + 2'd1;
            end else begin
              anim_cnt <= anim_cnt + 1'b1;
            end
          end
          BLOCKED: begin
            // dir still holds the direction that hit the wall
            if (pend_eff != dir) begin
              dir    <= pend_eff;
              px_x_q <= cl_x;
              px_y_q <= cl_y;
              state  <= MOVING;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [10:0] hx, vy;
  logic        s1_vis, s1_in, s1_hs, s1_vs;
  logic [3:0]  s1_dx, s1_dy;

  assign hx = {1'b0, bus.h} - {1'b0, px_x_q};
  assign vy = {1'b0, bus.v} - {1'b0, px_y_q};

  // Stage 1: visibility, sprite box test and in-sprite offsets
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vis <= 1'b0;
      s1_in  <= 1'b0;
      s1_dx  <= '0;
      s1_dy  <= '0;
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
    end else begin
      s1_vis <= (bus.h < 10'd640) && (bus.v < 10'd480);
      s1_in  <= !hx[10] && (hx[9:0] < 10'(SIZE)) && !vy[10] && (vy[9:0] < 10'(SIZE));
      s1_dx  <= hx[3:0];
      s1_dy  <= vy[3:0];
      s1_hs  <= bus.hs_in;
      s1_vs  <= bus.vs_in;
    end
  end

  logic signed [5:0] cx, cy, fwd, perp, aperp;
  logic signed [9:0] cx_w, cy_w, rad2;
  logic [6:0]        ap2;
  logic [1:0]        phase, face;
  logic              body, mouth;

  // Stage 2 combinational: centred coords, disc test, mouth wedge rotated into facing direction
  always_comb begin
    cx   = $signed({1'b0, s1_dx, 1'b0}) - 6'sd15;
    cy   = $signed({1'b0, s1_dy, 1'b0}) - 6'sd15;
    cx_w = $signed({{4{cx[5]}}, cx});
    cy_w = $signed({{4{cy[5]}}, cy});
    rad2 = cx_w * cx_w + cy_w * cy_w;
    body = s1_in && (rad2 <= 10'sd225);
    face = (state == IDLE) ? DIR_R : dir;
    case (face)
      DIR_R:   begin fwd = cx;  perp = cy; end
      DIR_L:   begin fwd = -cx; perp = cy; end
      DIR_U:   begin fwd = -cy; perp = cx; end
      default: begin fwd = cy;  perp = cx; end
    endcase
    aperp = perp[5] ? -perp : perp;
    ap2   = {aperp, 1'b0};
    phase = (pstep == 2'd2) ? WIDE : ((pstep[0]) ? OPEN : CLOSED);
    case (phase)
      WIDE:    mouth = (fwd > 6'sd0) && (aperp <= fwd);
      OPEN:    mouth = (fwd > 6'sd0) && (ap2 <= {1'b0, fwd});
      default: mouth = 1'b0;
    endcase
  end

  logic [3:0] r_q, g_q, b_q;
  logic       hs_q, vs_q;

  // Stage 2 registers: final colour and sync aligned to it
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      r_q  <= (s1_vis && body && !mouth) ? 4'hF : 4'h0;
      g_q  <= (s1_vis && body && !mouth) ? 4'hF : 4'h0;
      b_q  <= '0;
      hs_q <= s1_hs;
      vs_q <= s1_vs;
    end
  end

  assign bus.r          = r_q;
  assign bus.g          = g_q;
  assign bus.b          = b_q;
  assign bus.hs_out     = hs_q;
  assign bus.vs_out     = vs_q;
  assign bus.px_x       = px_x_q;
  assign bus.px_y       = px_y_q;
  assign bus.frame_tick = frame_tick_q;
endmodule
